// File: rtl/bpsk_demodulator.sv
// Coherent BPSK demodulator: multiply rx by the local carrier, integrate-and-dump
// over SPS samples, decide on the sign, and pack decided bits MSB-first into bytes.
module bpsk_demodulator #(
  parameter int SPS   = 16,
  parameter int ACC_W = 42
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sample_valid,
  input  logic signed [15:0] rx_sample,
  input  logic signed [15:0] carrier_in,
  input  logic               sym_start,
  output logic               locked,
  output logic               bit_valid,
  output logic               bit_out,
  output logic               byte_valid,
  output logic [7:0]         byte_out
);
  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(SPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, pos;
  logic             take, first, last, resync;

  logic signed [31:0]      rx_ext, car_ext, prod_reg;
  logic                    s1_valid, s1_first, s1_last, s1_resync;
  logic signed [ACC_W-1:0] acc_reg, prod_ext;
  logic                    s2_last, s2_resync;
  logic [7:0]              shift_reg, shift_next;
  logic [2:0]              bit_cnt_reg;

  // Decide what the currently offered sample means before it enters the pipeline.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    take       = 1'b0;
    resync     = 1'b0;
    pos        = cnt_reg;
    if (en && sample_valid) begin
      case (state_reg)
        IDLE: begin
          if (sym_start) begin
            state_next = RUN;
            take       = 1'b1;
          end
        end
        RUN: begin
          take = 1'b1;
          if (sym_start && cnt_reg != '0) resync = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
    if (resync) pos = '0;
    first = take && (pos == '0);
    last  = take && (pos == LAST_POS);
    if (take) cnt_next = last ? '0 : pos + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign locked     = (state_reg == RUN);
  assign rx_ext     = 32'(rx_sample);
  assign car_ext    = 32'(carrier_in);
  assign prod_ext   = {{(ACC_W-32){prod_reg[31]}}, prod_reg};
  assign shift_next = {shift_reg[6:0], acc_reg[ACC_W-1]};

  // Stage flags travel with each sample so the dump and resync happen in sample order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_reg    <= '0;
      s1_valid    <= 1'b0;
      s1_first    <= 1'b0;
      s1_last     <= 1'b0;
      s1_resync   <= 1'b0;
      acc_reg     <= '0;
      s2_last     <= 1'b0;
      s2_resync   <= 1'b0;
      bit_valid   <= 1'b0;
      bit_out     <= 1'b0;
      byte_valid  <= 1'b0;
      byte_out    <= 8'h00;
      shift_reg   <= 8'h00;
      bit_cnt_reg <= 3'd0;
    end else begin
      s1_valid  <= take;
      s1_first  <= first;
      s1_last   <= last;
      s1_resync <= resync;
      if (take) prod_reg <= rx_ext * car_ext;

      if (s1_valid) acc_reg <= s1_first ? prod_ext : acc_reg + prod_ext;
      s2_last   <= s1_valid && s1_last;
      s2_resync <= s1_valid && s1_resync;

      bit_valid  <= s2_last;
      byte_valid <= 1'b0;
      if (s2_resync) begin
        shift_reg   <= 8'h00;
        bit_cnt_reg <= 3'd0;
      end else if (s2_last) begin
        bit_out     <= acc_reg[ACC_W-1];
        shift_reg   <= shift_next;
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          byte_valid <= 1'b1;
          byte_out   <= shift_next;
        end
      end
    end
  end
endmodule

// File: doc/bpsk_demodulator.md
# bpsk_demodulator

Coherent BPSK demodulator for the receive path; the counterpart of the BPSK modulator built around the DDS sine generator. Each received 16-bit sample is multiplied by a phase-aligned local carrier sample from a second DDS instance. The products are integrated over one symbol period and dumped, and the sign gives the bit decision. Decided bits are also packed MSB-first into bytes for the downstream framer.

## Interface
- SPS, 16: samples per symbol; integer 2..1024.
- ACC_W, 42: accumulator width in bits; must be ≥ 32 + ceil(log2(SPS)).
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- en  in  1  clock enable for sample acceptance.
- sample_valid  in  1  rx_sample and carrier_in valid this cycle.
- rx_sample  in  16  received sample, two's-complement signed.
- carrier_in  in  16  local reference carrier sample, two's-complement signed, phase-aligned with rx_sample.
- sym_start  in  1  qualifies the accepted sample as the first sample of a symbol.
- locked  out  1  high while in RUN state.
- bit_valid  out  1  one-cycle pulse; bit_out is valid.
- bit_out  out  1  decided bit: 0 if integral ≥ 0, 1 if integral < 0.
- byte_valid  out  1  one-cycle pulse; byte_out is valid.
- byte_out  out  8  last 8 decided bits, first bit in bit 7.

## Operation
- A sample is accepted when en = 1 and sample_valid = 1. No other cycle affects state.
- States:
  - IDLE: accepted samples with sym_start = 0 are discarded. An accepted sample with sym_start = 1 moves to RUN and becomes sample 0 of a symbol.
  - RUN: every accepted sample is integrated.
- Pipeline:
  - Stage 1 registers the signed product rx_sample × carrier_in, 32 bits.
  - Stage 2 sign-extends the product to ACC_W and adds it into the accumulator.
  - For the first sample of a symbol, stage 2 loads the product instead of adding, so there is no dead cycle between symbols.
- Sample counter:
  - Counts accepted samples in the current symbol, 0..SPS-1, then wraps to 0.
  - When the SPS-th sample has been accumulated, the decision stage compares the accumulator sign and emits bit_valid.
- Byte packing:
  - Bits shift into an 8-bit register MSB-first. A 3-bit bit counter tracks position.
  - On the 8th bit, byte_valid pulses in the same cycle as that bit's bit_valid, with byte_out holding the completed byte.
  - The bit counter wraps to 0.
- Resync: an accepted sample with sym_start = 1 while in RUN and counter ≠ 0 does the following:
  - Discards the partial integral; no bit is emitted for it.
  - Restarts the counter so this sample is sample 0.
  - Clears the bit counter and shift register; the partial byte is lost.
- sym_start on a sample whose counter is already 0 is a no-op (normal alignment).
- Arithmetic:
  - No saturation. ACC_W guarantees no overflow: |product| ≤ 2^30, and SPS products fit in 31 + ceil(log2(SPS)) magnitude bits.
  - Integral exactly 0 decides bit 0.
- Flush: pipeline stages advance every cycle regardless of en. Already-accepted samples complete even if en drops.

## Timing
- Reset values: locked 0, bit_valid 0, bit_out 0, byte_valid 0, byte_out 0x00. Counters, accumulator and shift register are 0; state is IDLE.
- Reset is asynchronous and may arrive mid-symbol. It immediately clears all state. Pipelined samples in flight are dropped and no bit_valid follows.
- Latency: the last sample of a symbol is accepted in cycle N. It is accumulated at edge N+1→N+2. bit_valid/bit_out are registered high in cycle N+3. This is a fixed 3-cycle latency independent of gaps.
- bit_valid and byte_valid are high for exactly one cycle per event.
- bit_out and byte_out hold their values until the next respective valid.
- With continuous input, one bit_valid occurs every SPS cycles.
- locked rises the cycle after the first accepted sym_start sample. It falls only on reset.
- Gaps (sample_valid = 0 or en = 0) stretch the symbol without changing the integral.

## Test plan
- Reset check: drive rst = 0 asynchronously mid-cycle → all outputs 0 at once, locked 0. After release, samples without sym_start produce no bit_valid.
- Loopback: feed carrier = 16-sample sine of amplitude 16000, SPS = 16, and rx = ±carrier for byte 0xA5 (bit 1 = inverted carrier), sym_start on the first sample.
  - Expect 8 bit_valid pulses with bits 1,0,1,0,0,1,0,1, each 3 cycles after the symbol's last sample.
  - Expect byte_valid with byte_out = 0xA5 on the 8th bit.
- Extremes: rx = carrier = −32768 for all 16 samples → integral 2^34, bit 0. rx = −32768, carrier = 32767 → bit 1; no overflow.
- Zero input: rx = 0 for one symbol → bit_out 0.
- Gaps: randomly deassert sample_valid and en between samples of the 0xA5 stream → identical bits and byte; only timing stretches.
- Resync and reset: assert sym_start on sample 5 of a symbol → no bit for the partial symbol, the next bit appears after 16 more samples, and the byte counter restarts. Assert rst mid-symbol → no stray bit_valid, and locked returns to 0.
